// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states, NZCV bit
// positions and ARM condition codes.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   localparam logic [3:0] CC_EQ = 4'h0;
   localparam logic [3:0] CC_NE = 4'h1;
   localparam logic [3:0] CC_CS = 4'h2;
   localparam logic [3:0] CC_CC = 4'h3;
   localparam logic [3:0] CC_MI = 4'h4;
   localparam logic [3:0] CC_PL = 4'h5;
   localparam logic [3:0] CC_VS = 4'h6;
   localparam logic [3:0] CC_VC = 4'h7;
   localparam logic [3:0] CC_HI = 4'h8;
   localparam logic [3:0] CC_LS = 4'h9;
   localparam logic [3:0] CC_GE = 4'hA;
   localparam logic [3:0] CC_LT = 4'hB;
   localparam logic [3:0] CC_GT = 4'hC;
   localparam logic [3:0] CC_LE = 4'hD;
   localparam logic [3:0] CC_AL = 4'hE;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational ARM condition check: cond code + NZCV -> pass. 0xF behaves as AL.
// Only instantiated when ALU_COND_EXEC_EN is defined.
module alu_cond_eval
   import alu_seq_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      n = nzcv[N_BIT];
      z = nzcv[Z_BIT];
      c = nzcv[C_BIT];
      v = nzcv[V_BIT];
      pass = 1'b1;
      case (cond)
         CC_EQ: pass = z;
         CC_NE: pass = ~z;
         CC_CS: pass = c;
         CC_CC: pass = ~c;
         CC_MI: pass = n;
         CC_PL: pass = ~n;
         CC_VS: pass = v;
         CC_VC: pass = ~v;
         CC_HI: pass = c & ~z;
         CC_LS: pass = ~c | z;
         CC_GE: pass = (n == v);
         CC_LT: pass = (n != v);
         CC_GT: pass = ~z & (n == v);
         CC_LE: pass = z | (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue controller for one combinational ALU slice: request handshake, settle wait,
// NZCV register, response handshake. Optional conditional execution: ALU_COND_EXEC_EN.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_s,
`ifdef ALU_COND_EXEC_EN
   input  logic [3:0]       req_cond,
`endif
   output logic [31:0]      alu_in1,
   output logic [31:0]      alu_in2,
   output logic [3:0]       alu_flag,
   output logic             alu_s,
   input  logic [31:0]      alu_result,
   input  logic [3:0]       alu_new_flag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [3:0]       rsp_flag,
   output logic             rsp_skipped,
   input  logic             flag_we,
   input  logic [3:0]       flag_wdata,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] op_count
);

   localparam int             WW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [WW-1:0]  LAT_M1 = WW'(ALU_LAT - 1);

   state_e           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
   logic             s_q, s_d;
   logic [3:0]       flags_q, flags_d, rflag_q, rflag_d, cap_flags;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture, cond_pass;

`ifdef ALU_COND_EXEC_EN
   logic [3:0] cond_q, cond_d;
   logic       skip_q, skip_d;

   // Condition is judged against the architectural flags as they stand at capture.
   alu_cond_eval u_cond (
      .cond (cond_q),
      .nzcv (flags_q),
      .pass (cond_pass)
   );
   assign rsp_skipped = skip_q;
`else
   assign cond_pass   = 1'b1;
   assign rsp_skipped = 1'b0;
`endif

   assign capture = (state_q == ST_EXEC) && (wait_q == '0);

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      a_d       = a_q;
      b_d       = b_q;
      s_d       = s_q;
      res_d     = res_q;
      flags_d   = flags_q;
      rflag_d   = rflag_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      cap_flags = (s_q & cond_pass) ? alu_new_flag : flags_q;
`ifdef ALU_COND_EXEC_EN
      cond_d    = cond_q;
      skip_d    = skip_q;
`endif
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               s_d     = req_s;
`ifdef ALU_COND_EXEC_EN
               cond_d  = req_cond;
`endif
               wait_d  = LAT_M1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (capture) begin
               res_d   = alu_result;
               flags_d = cap_flags;
               rflag_d = cap_flags;
`ifdef ALU_COND_EXEC_EN
               skip_d  = ~cond_pass;
`endif
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Direct load wins over a same-edge capture, and the response reports it.
      if (flag_we) begin
         flags_d = flag_wdata;
         if (capture) rflag_d = flag_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
         rflag_q <= '0;
         cnt_q   <= '0;
`ifdef ALU_COND_EXEC_EN
         cond_q  <= '0;
         skip_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         rflag_q <= rflag_d;
         cnt_q   <= cnt_d;
`ifdef ALU_COND_EXEC_EN
         cond_q  <= cond_d;
         skip_q  <= skip_d;
`endif
      end
   end

   assign alu_in1    = a_q;
   assign alu_in2    = b_q;
   assign alu_s      = s_q;
   assign alu_flag   = flags_q;
   assign flags      = flags_q;
   assign rsp_result = res_q;
   assign rsp_flag   = rflag_q;
   assign op_count   = cnt_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential issue controller sitting in front of one combinational ALU slice (AND, ADD, …) that takes the `[N,Z,C,V]` flag interface. It accepts operation requests over a valid/ready handshake and drives the slice's operands, flag-in and set-flags inputs. It holds the architectural NZCV flag register and returns the registered result and flags over a second valid/ready handshake. It is the hardware driver for the ALU slices, replacing stimulus-only benches in the datapath.

## Interface
- `ALU_LAT`, default 1: cycles the slice output is allowed to settle before capture; legal range ≥1.
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_a` in 32: operand 1.
- `req_b` in 32: operand 2.
- `req_s` in 1: update flags on completion.
- `req_cond` in 4: ARM-style condition code. Present only with `ALU_COND_EXEC_EN`.
- `alu_in1` out 32: operand 1 to the slice.
- `alu_in2` out 32: operand 2 to the slice.
- `alu_flag` out 4: current NZCV to the slice.
- `alu_s` out 1: set-flags bit to the slice.
- `alu_result` in 32: slice result.
- `alu_new_flag` in 4: slice flags out.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32: captured result.
- `rsp_flag` out 4: NZCV after this operation.
- `rsp_skipped` out 1: condition failed; result is don't-care. Tied 0 without the macro.
- `flag_we` in 1: direct flag register load.
- `flag_wdata` in 4: load value.
- `flags` out 4: architectural NZCV register. Bit 3=N, 2=Z, 1=C, 0=V.
- `op_count` out CNT_W: completed responses, wraps.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`, register a/b/s/(cond) into the operand registers, load the wait counter with ALU_LAT-1, and go to EXEC.
- **EXEC**
  - `alu_in1`/`alu_in2`/`alu_s` are driven from the operand registers; `alu_flag`=`flags`.
  - Counter decrements each cycle.
  - On the edge where counter==0:
    - Capture `alu_result` into `rsp_result`.
    - If s=1 and the condition passes, `flags`←`alu_new_flag`.
    - `rsp_flag`← the resulting flags value.
    - Go to RESP.
- **RESP**
  - `rsp_valid`=1; outputs are held stable until `rsp_ready`.
  - On handshake: `op_count`++ (wraps at 2^CNT_W−1 → 0), then go to IDLE.
- `req_ready`=0 in EXEC and RESP. There is no same-cycle re-accept on response handshake.
- Flag register write priority: `flag_we` beats an ALU capture on the same edge.
  - `rsp_flag` then reports `flag_wdata`.
  - `flag_we` is legal in any state.
- Operand registers are not cleared after use; `alu_*` outputs hold their last values in IDLE/RESP.

## Timing
- Values after reset: `req_ready`=1 once `rst_n` is released. `rsp_valid`=0. All of the following are 0: `rsp_result`, `rsp_flag`, `rsp_skipped`, `flags`, `op_count`, `alu_in1`, `alu_in2`, `alu_s`.
- Latency: accept at edge k → capture at edge k+ALU_LAT → `rsp_valid` high from the cycle after k+ALU_LAT.
- Throughput, with `rsp_ready` held high: one op per ALU_LAT+2 cycles.
- `rsp_ready` asserted while `rsp_valid`=0 is ignored.
- `rsp_valid`, once high, never drops without a handshake.
- `rst_n` asserted mid-EXEC or mid-RESP aborts immediately to the reset values. The in-flight op is lost, and `flags`/`op_count` clear.
- `flag_we` in EXEC is visible on `alu_flag` from the next cycle. That value is stale for the slice's C-in, which is accepted behaviour.

## Configuration
- `ALU_COND_EXEC_EN` defined:
  - The `req_cond` port exists and is registered at accept.
  - Cond is evaluated against `flags` at capture time. Use the ARM table 0x0 EQ … 0xE AL; 0xF is treated as AL.
  - Fail: no flag update, `rsp_skipped`=1, response still issued and counted.
- `ALU_COND_EXEC_EN` undefined:
  - No `req_cond` port.
  - Every op passes; `rsp_skipped` is constant 0.

## Structure
- Package `alu_seq_pkg` contains:
  - FSM state enum.
  - NZCV bit index constants (N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0).
  - 4-bit condition-code constants.
- Sub-module `alu_cond_eval` is a combinational cond+NZCV→pass function. It is instantiated only under the macro.

## Test plan
- Bench connects the AND slice, ALU_LAT=1.
- Test 1: a=2, b=3, s=1 → `rsp_result`=2, `flags`=0000, `rsp_valid` in the 2nd cycle after accept.
- Test 2: a=0, b=0, s=1 → `rsp_result`=0, `flags`=0100; then a=0xFFFFFFFF, b=9, s=0 → `rsp_result`=9, `flags` still 0100.
- Test 3: hold `rsp_ready`=0 for 5 cycles → `rsp_valid`, `rsp_result` stable, `req_ready`=0 throughout, `op_count` unchanged until the handshake.
- Test 4: `flag_we`=1, `flag_wdata`=1010 on the capture edge of an s=1 op yielding 0100 → `flags`=1010, `rsp_flag`=1010.
- Test 5: preload `op_count` to 0xFFFF by running 65535 ops, then one more → 0x0000. Separately, drop `rst_n` mid-EXEC → all outputs at reset values, next request handled normally.
- Test 6, with the macro: `flags`=0000, cond=EQ(0x0), a=b=0, s=1 → `rsp_skipped`=1, `flags` stays 0000; cond=AL(0xE) → `flags`=0100, skipped=0.
